// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and constants for the memory arbiter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam word_t ERR_WORD = 32'hBAD1BAD1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - grant choice between instruction and data requesters
module arb_pick #(
  parameter int STARVE_MAX = 4,
  parameter int CW         = 3
) (
  input  logic          i_ireq,
  input  logic          i_dreq,
  input  logic [CW-1:0] i_starve_cnt,
  output logic          o_gnt_i,
  output logic          o_gnt_d
);

  logic w_starved;

  // Data normally wins; a pending fetch overrides once data has had its quota.
  assign w_starved = (i_starve_cnt == CW'(STARVE_MAX));
  assign o_gnt_d   = i_dreq & ~(i_ireq & w_starved);
  assign o_gnt_i   = i_ireq & ~o_gnt_d;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data arbiter onto a single RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        memerr
);

  localparam int SCW = $clog2(STARVE_MAX + 2);
  localparam int TCW = $clog2(TIMEOUT + 1);

  arb_state_t     r_state, w_next;
  word_t          r_addr, r_store, r_iload, r_dload;
  logic           r_wr, r_memerr;
  logic [SCW-1:0] r_starve;
  logic [TCW-1:0] r_tmo;

  ramstate_t w_rs;
  word_t     w_resp;
  logic      w_dreq, w_granted, w_own_en, w_tmo_hit, w_err;
  logic      w_done, w_abort, w_arb, w_gnt_i, w_gnt_d;

  assign w_rs      = ramstate_t'(ramstate);
  assign w_dreq    = dREN | dWEN;
  assign w_granted = (r_state != IDLE);
  assign w_own_en  = (r_state == IGNT) ? iREN : w_dreq;
  assign w_tmo_hit = (r_tmo == TCW'(TIMEOUT - 1)) && (w_rs != ACCESS);
  assign w_err     = (w_rs == ERROR) || w_tmo_hit;
  // Completion wins over a same-cycle enable drop, so the owner may release its request as it completes.
  assign w_done    = w_granted && ((w_rs == ACCESS) || w_err);
  assign w_abort   = w_granted && !w_done && !w_own_en;
  assign w_arb     = (r_state == IDLE) || w_done;
  assign w_resp    = w_err ? ERR_WORD : ramload;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CW         (SCW)
  ) u_pick (
    .i_ireq       (iREN),
    .i_dreq       (w_dreq),
    .i_starve_cnt (r_starve),
    .o_gnt_i      (w_gnt_i),
    .o_gnt_d      (w_gnt_d)
  );

  always_comb begin
    w_next = r_state;
    if (w_arb) begin
      if (w_gnt_d)      w_next = DGNT;
      else if (w_gnt_i) w_next = IGNT;
      else              w_next = IDLE;
    end else if (w_abort) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_store  <= '0;
      r_wr     <= 1'b0;
      r_iload  <= '0;
      r_dload  <= '0;
      r_memerr <= 1'b0;
      r_starve <= '0;
      r_tmo    <= '0;
    end else begin
      r_state <= w_next;
      if (w_arb && w_gnt_d) begin
        r_addr  <= daddr;
        r_store <= dstore;
        r_wr    <= dWEN;
      end else if (w_arb && w_gnt_i) begin
        r_addr <= iaddr;
        r_wr   <= 1'b0;
      end
      if (!iREN || (w_arb && w_gnt_i))
        r_starve <= '0;
      else if (w_arb && w_gnt_d)
        r_starve <= r_starve + SCW'(1);
      if (!w_granted || w_done || w_abort)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TCW'(1);
      if (!iwait) r_iload <= w_resp;
      if (!dwait) r_dload <= w_resp;
      if (w_done && w_err) r_memerr <= 1'b1;
    end
  end

  assign iwait    = !((r_state == IGNT) && w_done);
  assign dwait    = !((r_state == DGNT) && w_done);
  assign iload    = iwait ? r_iload : w_resp;
  assign dload    = dwait ? r_dload : w_resp;
  assign ramREN   = (r_state == IGNT) || ((r_state == DGNT) && !r_wr);
  assign ramWEN   = (r_state == DGNT) && r_wr;
  assign ramaddr  = r_addr;
  assign ramstore = r_store;
  assign memerr   = r_memerr;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, memerr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  typedef struct {
    bit          is_i;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(64), .STARVE_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample completions mid-cycle against the scoreboard, then step past the edge.
  task automatic cyc();
    exp_t e;
    @(negedge CLK);
    if (iwait === 1'b0 || dwait === 1'b0) begin
      if (sb.size() == 0) begin
        chk("spurious_done", {30'd0, iwait, dwait}, 32'd3);
      end else begin
        e = sb.pop_front();
        chk("done_waits", {30'd0, iwait, dwait}, e.is_i ? 32'd1 : 32'd2);
        chk("done_load", e.is_i ? iload : dload, e.data);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_en"},    {30'd0, ramREN, ramWEN}, 32'd0);
    chk({tag, "_addr"},  ramaddr, 32'd0);
    chk({tag, "_store"}, ramstore, 32'd0);
    chk({tag, "_waits"}, {29'd0, iwait, dwait, memerr}, 32'd6);
    chk({tag, "_iload"}, iload, 32'd0);
    chk({tag, "_dload"}, dload, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    #1;
    cyc(); cyc();
    chk_reset_outputs("reset");
    nRST = 1'b1;

    // Lone fetch: two BUSY cycles then ACCESS.
    iREN = 1'b1; iaddr = 32'h40;
    cyc();
    chk("fetch_ren", {30'd0, ramREN, ramWEN}, 32'd2);
    chk("fetch_addr", ramaddr, 32'h40);
    ramstate = BUSY;
    cyc(); cyc();
    ramstate = ACCESS; ramload = 32'h8C010000; iREN = 1'b0;
    sb.push_back('{1'b1, 32'h8C010000});
    cyc();
    ramstate = FREE;
    chk("fetch_idle", {31'd0, ramREN}, 32'd0);
    cyc();

    // Simultaneous requests: data first, then fetch with no idle gap.
    iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h200;
    cyc();
    chk("sim_d_first", {30'd0, ramREN, ramWEN}, 32'd2);
    chk("sim_d_addr", ramaddr, 32'h200);
    ramstate = ACCESS; ramload = 32'h11112222; dREN = 1'b0;
    sb.push_back('{1'b0, 32'h11112222});
    cyc();
    chk("sim_i_next", ramaddr, 32'h80);
    chk("sim_i_ren", {31'd0, ramREN}, 32'd1);
    ramload = 32'h33334444; iREN = 1'b0;
    sb.push_back('{1'b1, 32'h33334444});
    cyc();
    ramstate = FREE;
    cyc();

    // Starvation: four data grants, then the fetch wins.
    iREN = 1'b1; iaddr = 32'h90; dREN = 1'b1; daddr = 32'h300; ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      ramload = 32'h55000000 + k;
      if (k >= 1 && k <= 4) sb.push_back('{1'b0, ramload});
      if (k == 5) begin
        sb.push_back('{1'b1, ramload});
        iREN = 1'b0; dREN = 1'b0;
      end
      cyc();
    end
    ramstate = FREE;
    chk("starve_idle", {30'd0, ramREN, ramWEN}, 32'd0);

    // Read+write together behaves as a write with latched, stable operands.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
    cyc();
    chk("wr_en", {30'd0, ramREN, ramWEN}, 32'd1);
    chk("wr_store", ramstore, 32'hDEADBEEF);
    daddr = 32'h999; dstore = 32'h0;
    cyc();
    chk("wr_addr_hold", ramaddr, 32'h100);
    chk("wr_store_hold", ramstore, 32'hDEADBEEF);
    ramstate = ACCESS; ramload = 32'h12345678; dREN = 1'b0; dWEN = 1'b0;
    sb.push_back('{1'b0, 32'h12345678});
    cyc();
    ramstate = FREE;

    // RAM error completion and sticky memerr.
    chk("err_pre", {31'd0, memerr}, 32'd0);
    dREN = 1'b1; daddr = 32'h10; ramstate = BUSY;
    cyc();
    ramstate = ERROR; ramload = 32'h7777; dREN = 1'b0;
    sb.push_back('{1'b0, ERR_WORD});
    cyc();
    chk("err_memerr", {31'd0, memerr}, 32'd1);
    ramstate = FREE;
    cyc(); cyc();
    chk("err_sticky", {31'd0, memerr}, 32'd1);
    nRST = 1'b0;
    cyc();
    nRST = 1'b1;
    chk("err_cleared", {31'd0, memerr}, 32'd0);

    // Timeout: 64 granted BUSY cycles force an error completion.
    dREN = 1'b1; daddr = 32'h20; ramstate = BUSY; ramload = 32'h4444;
    cyc();
    for (int k = 1; k < 64; k++) cyc();
    dREN = 1'b0;
    sb.push_back('{1'b0, ERR_WORD});
    cyc();
    chk("tmo_memerr", {31'd0, memerr}, 32'd1);
    chk("tmo_idle", {30'd0, ramREN, ramWEN}, 32'd0);
    ramstate = FREE;

    // Abort: fetch dropped mid-BUSY gives no pulse and releases the RAM.
    iREN = 1'b1; iaddr = 32'h44; ramstate = BUSY;
    cyc();
    chk("abort_ren", {31'd0, ramREN}, 32'd1);
    cyc();
    iREN = 1'b0;
    cyc();
    chk("abort_released", {31'd0, ramREN}, 32'd0);
    ramstate = ACCESS;
    cyc();
    ramstate = BUSY;

    // Reset in the middle of a data write grant.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h60; dstore = 32'hCAFE;
    cyc();
    chk("rst_pre_wen", {31'd0, ramWEN}, 32'd1);
    nRST = 1'b0;
    cyc();
    chk_reset_outputs("midrst");
    dREN = 1'b0; dWEN = 1'b0; nRST = 1'b1; ramstate = FREE;
    cyc(); cyc();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
